decode_queue: RTL and testbench

// Instruction queue plus multi-lane decode stage between fetch and issue. Buffers fetch packets of up to

---
 rtl/decode_queue_pkg.sv | 88 ++++++++
 rtl/decode_queue_decoder.sv | 121 ++++++++++++
 rtl/decode_queue_fifo.sv | 56 +++++
 rtl/decode_queue.sv | 115 +++++++++++
 tb/tb_decode_queue.sv | 379 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/decode_queue_pkg.sv
// Shared types for the instruction queue and decode stage.
// Entry, decoded-control bundle, privilege encoding and helpers.
package decode_queue_pkg;

  typedef enum logic [1:0] {
    PRIV_U = 2'b00,
    PRIV_S = 2'b01,
    PRIV_M = 2'b11
  } rv_priv;

  typedef enum logic [3:0] {
    ALU_NONE,
    ALU_ADD,
    ALU_SUB,
    ALU_SLL,
    ALU_SLT,
    ALU_SLTU,
    ALU_XOR,
    ALU_SRL,
    ALU_SRA,
    ALU_OR,
    ALU_AND
  } alu_op_e;

  typedef struct packed {
    alu_op_e    alu_opt;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       rd_en;
    logic       use_imm;
    logic       load;
    logic       store;
    logic       branch;
    logic       jump;
    logic       csr_en;
    logic       fence_i;
    logic       flush_pipe;
    logic       ecall;
    logic       ebreak;
    logic       mret;
  } decode_pack;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
    logic        fault;
  } iq_entry;

  localparam logic [6:0] OPC_OPIMM  = 7'h13;
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_JAL    = 7'h6f;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_MISC   = 7'h0f;
  localparam logic [6:0] OPC_SYSTEM = 7'h73;

  localparam logic [31:0] INSN_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INSN_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INSN_MRET   = 32'h3020_0073;

  function automatic alu_op_e alu_of(logic [2:0] f3, logic alt);
    alu_op_e op;
    unique case (f3)
      3'd0: op = alt ? ALU_SUB : ALU_ADD;
      3'd1: op = ALU_SLL;
      3'd2: op = ALU_SLT;
      3'd3: op = ALU_SLTU;
      3'd4: op = ALU_XOR;
      3'd5: op = alt ? ALU_SRA : ALU_SRL;
      3'd6: op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  function automatic logic is_serialising(
    decode_pack p, logic illegal, logic fault
  );
    return fault | illegal | p.csr_en | p.fence_i
         | p.flush_pipe | p.ecall | p.ebreak | p.mret;
  endfunction

endpackage

// File: rtl/decode_queue_decoder.sv
// Single-instruction RV64 decoder; all outputs zero when en=0.
// MRET legality follows the live privilege input.
module rv_decoder
  import decode_queue_pkg::*;
(
  input  logic        en,
  input  logic [31:0] instr,
  input  rv_priv      priv,
  output decode_pack  pack,
  output logic [63:0] imm,
  output logic        illegal
);
  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic [63:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opc = instr[6:0];
  assign f3  = instr[14:12];
  assign f7  = instr[31:25];

  assign imm_i = {{52{instr[31]}}, instr[31:20]};
  assign imm_s = {{52{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{51{instr[31]}}, instr[31], instr[7],
                  instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {{32{instr[31]}}, instr[31:12], 12'b0};
  assign imm_j = {{43{instr[31]}}, instr[31], instr[19:12],
                  instr[20], instr[30:21], 1'b0};

  always_comb begin
    pack    = '0;
    imm     = '0;
    illegal = 1'b0;
    if (en) begin
      pack.rd  = instr[11:7];
      pack.rs1 = instr[19:15];
      pack.rs2 = instr[24:20];
      unique case (1'b1)
        opc == OPC_OPIMM: begin
          pack.rd_en   = 1'b1;
          pack.use_imm = 1'b1;
          pack.alu_opt = alu_of(f3, f3 == 3'd5 && instr[30]);
          imm          = imm_i;
          illegal = (f3 == 3'd1 && instr[31:26] != 6'h00)
                 || (f3 == 3'd5 && instr[31:26] != 6'h00
                     && instr[31:26] != 6'h10);
        end
        opc == OPC_OP: begin
          pack.rd_en   = 1'b1;
          pack.alu_opt = alu_of(f3, instr[30]);
          illegal = !(f7 == 7'h00
                   || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
        end
        opc == OPC_LUI, opc == OPC_AUIPC: begin
          pack.rd_en   = 1'b1;
          pack.use_imm = 1'b1;
          pack.alu_opt = ALU_ADD;
          imm          = imm_u;
        end
        opc == OPC_JAL: begin
          pack.rd_en = 1'b1;
          pack.jump  = 1'b1;
          imm        = imm_j;
        end
        opc == OPC_JALR: begin
          pack.rd_en   = 1'b1;
          pack.jump    = 1'b1;
          pack.use_imm = 1'b1;
          imm          = imm_i;
          illegal      = f3 != 3'd0;
        end
        opc == OPC_BRANCH: begin
          pack.branch = 1'b1;
          imm         = imm_b;
          illegal     = f3[2:1] == 2'b01;
        end
        opc == OPC_LOAD: begin
          pack.load    = 1'b1;
          pack.rd_en   = 1'b1;
          pack.use_imm = 1'b1;
          pack.alu_opt = ALU_ADD;
          imm          = imm_i;
          illegal      = f3 == 3'd7;
        end
        opc == OPC_STORE: begin
          pack.store   = 1'b1;
          pack.use_imm = 1'b1;
          pack.alu_opt = ALU_ADD;
          imm          = imm_s;
          illegal      = f3[2];
        end
        opc == OPC_MISC: begin
          pack.fence_i    = f3 == 3'd1;
          pack.flush_pipe = f3 == 3'd1;
          illegal         = f3[2:1] != 2'b00;
        end
        opc == OPC_SYSTEM: begin
          if (f3 == 3'd0) begin
            if (instr == INSN_ECALL)
              pack.ecall = 1'b1;
            else if (instr == INSN_EBREAK)
              pack.ebreak = 1'b1;
            else if (instr == INSN_MRET) begin
              pack.mret = 1'b1;
              illegal   = priv != PRIV_M;
            end else
              illegal = 1'b1;
          end else begin
            // imm carries the CSR address for the CSR unit
            pack.csr_en = 1'b1;
            pack.rd_en  = 1'b1;
            imm         = {52'b0, instr[31:20]};
            illegal     = f3 == 3'd4;
          end
        end
        default: illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/decode_queue_fifo.sv
// Ring buffer with variable-count push/pop and windowed reads.
// Flush drops same-cycle traffic and rewinds both pointers.
module iq_fifo #(
  parameter int WIDTH  = 97,
  parameter int DEPTH  = 8,
  parameter int PUSH_W = 2,
  parameter int POP_W  = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  logic [$clog2(PUSH_W+1)-1:0] push_n,
  input  logic [PUSH_W-1:0][WIDTH-1:0] push_data,
  input  logic [$clog2(POP_W+1)-1:0] pop_n,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [POP_W-1:0][WIDTH-1:0] rd_data
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push_n);
      rd_ptr <= rd_ptr + AW'(pop_n);
      count  <= count + CW'(push_n) - CW'(pop_n);
    end
  end

  always_ff @(posedge clk) begin
    if (!flush) begin
      for (int k = 0; k < PUSH_W; k++) begin
        if (k < int'(push_n))
          mem[wr_ptr + AW'(k)] <= push_data[k];
      end
    end
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < POP_W; i++)
      rd_data[i] = mem[rd_ptr + AW'(i)];
  end

endmodule

// File: rtl/decode_queue.sv
// Instruction queue plus multi-lane decode between fetch and issue.
// Serialising entries are only ever presented alone on lane 0.
module decode_queue
  import decode_queue_pkg::*;
#(
  parameter int FETCH_W  = 2,
  parameter int DECODE_W = 2,
  parameter int DEPTH    = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  rv_priv priv_mode,
  input  logic in_valid,
  output logic in_ready,
  input  logic [63:0] in_pc,
  input  logic [FETCH_W-1:0][31:0] in_instr,
  input  logic [FETCH_W-1:0] in_mask,
  input  logic in_fault,
  output logic [DECODE_W-1:0] out_valid,
  output logic [DECODE_W-1:0][63:0] out_pc,
  output logic [DECODE_W-1:0][31:0] out_instr,
  output decode_pack [DECODE_W-1:0] out_pack,
  output logic [DECODE_W-1:0][63:0] out_imm,
  output logic [DECODE_W-1:0] out_illegal,
  output logic [DECODE_W-1:0] out_fault,
  input  logic [$clog2(DECODE_W+1)-1:0] out_accept
);
  localparam int PW = $clog2(FETCH_W+1);
  localparam int CW = $clog2(DEPTH+1);
  localparam int EW = $bits(iq_entry);

  logic [CW-1:0] count;
  logic [PW-1:0] push_n;
  iq_entry [FETCH_W-1:0] push_data;
  iq_entry [DECODE_W-1:0] rd_data;
  decode_pack [DECODE_W-1:0] dec_pack;
  logic [DECODE_W-1:0][63:0] dec_imm;
  logic [DECODE_W-1:0] cand, dec_ill, ser, valid;

  assign in_ready = (DEPTH - int'(count)) >= FETCH_W;

  always_comb begin
    push_n    = '0;
    push_data = '0;
    for (int k = 0; k < FETCH_W; k++) begin
      push_data[k].pc    = in_pc + 64'(4 * k);
      push_data[k].instr = in_instr[k];
      push_data[k].fault = in_fault;
      if (in_valid && in_ready && in_mask[k])
        push_n = push_n + PW'(1);
    end
  end

  iq_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH),
    .PUSH_W(FETCH_W),
    .POP_W (DECODE_W)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .push_n   (push_n),
    .push_data(push_data),
    .pop_n    (out_accept),
    .count    (count),
    .rd_data  (rd_data)
  );

  for (genvar i = 0; i < DECODE_W; i++) begin : g_lane
    assign cand[i] = int'(count) > i;

    rv_decoder u_dec (
      .en     (cand[i] && !rd_data[i].fault),
      .instr  (rd_data[i].instr),
      .priv   (priv_mode),
      .pack   (dec_pack[i]),
      .imm    (dec_imm[i]),
      .illegal(dec_ill[i])
    );

    assign ser[i] = is_serialising(dec_pack[i], dec_ill[i],
                                   rd_data[i].fault);

    assign out_pc[i]      = valid[i] ? rd_data[i].pc : '0;
    assign out_instr[i]   = valid[i] ? rd_data[i].instr : '0;
    assign out_fault[i]   = valid[i] && rd_data[i].fault;
    assign out_pack[i]    = valid[i] ? dec_pack[i] : '0;
    assign out_imm[i]     = valid[i] ? dec_imm[i] : '0;
    assign out_illegal[i] = valid[i] && dec_ill[i];
  end

  // Lane 0 may be serialising but then stands alone.
  always_comb begin
    logic stop;
    valid = '0;
    stop  = 1'b0;
    for (int i = 0; i < DECODE_W; i++) begin
      if (!cand[i] || stop) begin
        stop = 1'b1;
      end else if (i == 0) begin
        valid[0] = 1'b1;
        stop     = ser[0];
      end else if (ser[i]) begin
        stop = 1'b1;
      end else begin
        valid[i] = 1'b1;
      end
    end
  end

  assign out_valid = valid;

endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue: ordering, full/empty, serialise,
// fault tagging, flush, privilege re-evaluation, wrap and async reset.
module tb_decode_queue;
  import decode_queue_pkg::*;

  localparam logic [31:0] ADDI1 = 32'h0010_0093;
  localparam logic [31:0] ADDI2 = 32'h0020_0113;
  localparam logic [31:0] ADD3  = 32'h0020_81B3;
  localparam logic [31:0] CSRRW = 32'h3001_10F3;
  localparam logic [31:0] MRET  = 32'h3020_0073;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  rv_priv priv_mode;
  logic in_valid;
  logic in_ready;
  logic [63:0] in_pc;
  logic [1:0][31:0] in_instr;
  logic [1:0] in_mask;
  logic in_fault;
  logic [1:0] out_valid;
  logic [1:0][63:0] out_pc;
  logic [1:0][31:0] out_instr;
  decode_pack [1:0] out_pack;
  logic [1:0][63:0] out_imm;
  logic [1:0] out_illegal;
  logic [1:0] out_fault;
  logic [1:0] out_accept;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  decode_queue dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .priv_mode(priv_mode),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_instr(in_instr),
    .in_mask(in_mask), .in_fault(in_fault),
    .out_valid(out_valid), .out_pc(out_pc),
    .out_instr(out_instr), .out_pack(out_pack),
    .out_imm(out_imm), .out_illegal(out_illegal),
    .out_fault(out_fault), .out_accept(out_accept)
  );

  always @(negedge clk) begin
    if (rst_n && int'(out_accept) > $countones(out_valid)) begin
      n_fail++;
      $display("FAIL accept_le_valid: accept=%0d valid=%b",
               out_accept, out_valid);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_pkt(logic [63:0] pc, logic [31:0] i0,
                          logic [31:0] i1, logic [1:0] m, logic f);
    in_valid = 1'b1;
    in_pc = pc;
    in_instr[0] = i0;
    in_instr[1] = i1;
    in_mask = m;
    in_fault = f;
    cyc();
    in_valid = 1'b0;
    in_fault = 1'b0;
  endtask

  task automatic pop(logic [1:0] n);
    out_accept = n;
    cyc();
    out_accept = 2'd0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_chk++;
    if (out_valid !== 2'b00) begin
      n_fail++; $display("FAIL rst_valid: got %b want 00", out_valid);
    end
    n_chk++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL rst_ready: got %b want 1", in_ready);
    end
    n_chk++;
    if (out_pc !== '0 || out_pack !== '0) begin
      n_fail++; $display("FAIL rst_lanes: pc=%h pack=%h want 0",
                         out_pc, out_pack);
    end
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    in_valid = 1'b1;
    in_pc = 64'h1000;
    in_instr[0] = ADDI1;
    in_instr[1] = ADDI2;
    in_mask = 2'b11;
    #1;
    n_chk++;
    if (out_valid !== 2'b00) begin
      n_fail++; $display("FAIL no_bypass: got %b want 00", out_valid);
    end
    cyc();
    in_valid = 1'b0;
    n_chk++;
    if (out_valid !== 2'b11) begin
      n_fail++; $display("FAIL basic_valid: got %b want 11", out_valid);
    end
    n_chk++;
    if (out_pc[0] !== 64'h1000 || out_pc[1] !== 64'h1004) begin
      n_fail++; $display("FAIL basic_pc: got %h/%h want 1000/1004",
                         out_pc[0], out_pc[1]);
    end
    n_chk++;
    if (out_pack[0].alu_opt !== ALU_ADD || out_pack[1].alu_opt !== ALU_ADD) begin
      n_fail++; $display("FAIL basic_alu: got %0d/%0d want ADD",
                         out_pack[0].alu_opt, out_pack[1].alu_opt);
    end
    n_chk++;
    if (out_imm[0] !== 64'd1 || out_imm[1] !== 64'd2) begin
      n_fail++; $display("FAIL basic_imm: got %0d/%0d want 1/2",
                         out_imm[0], out_imm[1]);
    end
    pop(2'd2);
  endtask

  task automatic test_full();
    for (int p = 0; p < 4; p++)
      push_pkt(64'h2000 + 64'(8 * p), ADDI1, ADDI2, 2'b11, 1'b0);
    n_chk++;
    if (dut.count !== 4'd8 || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL full: count=%0d ready=%b want 8/0",
                         dut.count, in_ready);
    end
    in_valid = 1'b1;
    in_pc = 64'h2F00;
    out_accept = 2'd2;
    cyc();
    in_valid = 1'b0;
    out_accept = 2'd0;
    n_chk++;
    if (dut.count !== 4'd6 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL full_pop: count=%0d ready=%b want 6/1",
                         dut.count, in_ready);
    end
    n_chk++;
    if (out_pc[0] !== 64'h2008) begin
      n_fail++; $display("FAIL full_head: got %h want 2008", out_pc[0]);
    end
    for (int p = 2; p <= 4; p++) begin
      pop(2'd2);
      if (p < 4) begin
        n_chk++;
        if (out_pc[0] !== 64'h2000 + 64'(8 * p)) begin
          n_fail++; $display("FAIL drain_pc: got %h want %h",
                             out_pc[0], 64'h2000 + 64'(8 * p));
        end
      end
    end
    n_chk++;
    if (out_valid !== 2'b00) begin
      n_fail++; $display("FAIL drain_empty: got %b want 00", out_valid);
    end
  endtask

  task automatic test_serialise();
    push_pkt(64'h3000, ADD3, CSRRW, 2'b11, 1'b0);
    push_pkt(64'h3008, ADD3, ADD3, 2'b11, 1'b0);
    n_chk++;
    if (out_valid !== 2'b01 || out_pc[0] !== 64'h3000) begin
      n_fail++; $display("FAIL ser_a: valid=%b pc=%h want 01/3000",
                         out_valid, out_pc[0]);
    end
    pop(2'd1);
    n_chk++;
    if (out_valid !== 2'b01 || out_pack[0].csr_en !== 1'b1
        || out_pc[0] !== 64'h3004) begin
      n_fail++; $display("FAIL ser_csr: valid=%b csr=%b pc=%h want 01/1/3004",
                         out_valid, out_pack[0].csr_en, out_pc[0]);
    end
    n_chk++;
    if (out_imm[0] !== 64'h300 || out_instr[0] !== CSRRW) begin
      n_fail++; $display("FAIL ser_csr_imm: imm=%h instr=%h want 300/%h",
                         out_imm[0], out_instr[0], CSRRW);
    end
    pop(2'd1);
    n_chk++;
    if (out_valid !== 2'b11 || out_pc[1] !== 64'h300C) begin
      n_fail++; $display("FAIL ser_after: valid=%b pc1=%h want 11/300c",
                         out_valid, out_pc[1]);
    end
    pop(2'd2);
  endtask

  task automatic test_fault();
    push_pkt(64'h4000, ADDI1, ADDI2, 2'b11, 1'b1);
    n_chk++;
    if (out_valid !== 2'b01 || out_fault !== 2'b01) begin
      n_fail++; $display("FAIL fault_a: valid=%b fault=%b want 01/01",
                         out_valid, out_fault);
    end
    n_chk++;
    if (out_pack[0] !== decode_pack'('0) || out_illegal !== 2'b00
        || out_imm[0] !== 64'd0) begin
      n_fail++; $display("FAIL fault_zero: pack=%h ill=%b imm=%h want 0",
                         out_pack[0], out_illegal, out_imm[0]);
    end
    pop(2'd1);
    n_chk++;
    if (out_valid !== 2'b01 || out_fault !== 2'b01
        || out_pc[0] !== 64'h4004) begin
      n_fail++; $display("FAIL fault_b: valid=%b fault=%b pc=%h want 01/01/4004",
                         out_valid, out_fault, out_pc[0]);
    end
    pop(2'd1);
  endtask

  task automatic test_priv();
    push_pkt(64'h4800, MRET, ADDI1, 2'b11, 1'b0);
    n_chk++;
    if (out_valid !== 2'b01 || out_illegal !== 2'b00
        || out_pack[0].mret !== 1'b1) begin
      n_fail++; $display("FAIL mret_m: valid=%b ill=%b mret=%b want 01/00/1",
                         out_valid, out_illegal, out_pack[0].mret);
    end
    priv_mode = PRIV_U;
    #1;
    n_chk++;
    if (out_illegal !== 2'b01 || out_valid !== 2'b01) begin
      n_fail++; $display("FAIL mret_u: ill=%b valid=%b want 01/01",
                         out_illegal, out_valid);
    end
    priv_mode = PRIV_M;
    pop(2'd1);
    n_chk++;
    if (out_valid !== 2'b01 || out_pc[0] !== 64'h4804) begin
      n_fail++; $display("FAIL mret_next: valid=%b pc=%h want 01/4804",
                         out_valid, out_pc[0]);
    end
    pop(2'd1);
  endtask

  task automatic test_flush();
    push_pkt(64'h5000, ADDI1, ADDI2, 2'b11, 1'b0);
    push_pkt(64'h5008, ADDI1, ADDI2, 2'b11, 1'b0);
    push_pkt(64'h5010, ADDI1, ADDI2, 2'b01, 1'b0);
    n_chk++;
    if (dut.count !== 4'd5) begin
      n_fail++; $display("FAIL flush_pre: count=%0d want 5", dut.count);
    end
    flush = 1'b1;
    in_valid = 1'b1;
    in_pc = 64'h5100;
    in_mask = 2'b11;
    out_accept = 2'd2;
    #1;
    n_chk++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL flush_ready: got %b want 1", in_ready);
    end
    cyc();
    flush = 1'b0;
    in_valid = 1'b0;
    out_accept = 2'd0;
    n_chk++;
    if (out_valid !== 2'b00 || dut.count !== 4'd0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL flush_post: valid=%b count=%0d ready=%b want 00/0/1",
                         out_valid, dut.count, in_ready);
    end
    n_chk++;
    if (dut.u_fifo.rd_ptr !== 3'd0 || dut.u_fifo.wr_ptr !== 3'd0) begin
      n_fail++; $display("FAIL flush_ptr: rd=%0d wr=%0d want 0/0",
                         dut.u_fifo.rd_ptr, dut.u_fifo.wr_ptr);
    end
    push_pkt(64'h5200, ADDI1, ADDI2, 2'b01, 1'b0);
    n_chk++;
    if (out_valid !== 2'b01 || out_pc[0] !== 64'h5200) begin
      n_fail++; $display("FAIL flush_next: valid=%b pc=%h want 01/5200",
                         out_valid, out_pc[0]);
    end
    pop(2'd1);
  endtask

  task automatic test_back_to_back();
    logic [63:0] q[$];
    logic [63:0] pc;
    logic [1:0] ev;
    int pushed, acc, nv;
    logic push;
    pc = 64'h6000;
    pushed = 0;
    for (int c = 0; c < 60; c++) begin
      nv = q.size() > 2 ? 2 : q.size();
      ev = 2'((1 << nv) - 1);
      n_chk++;
      if (out_valid !== ev) begin
        n_fail++; $display("FAIL wrap_valid c%0d: got %b want %b",
                           c, out_valid, ev);
      end
      for (int i = 0; i < 2; i++) begin
        if (i < nv) begin
          n_chk++;
          if (out_pc[i] !== q[i]) begin
            n_fail++; $display("FAIL wrap_pc c%0d l%0d: got %h want %h",
                               c, i, out_pc[i], q[i]);
          end
        end
      end
      n_chk++;
      if (in_ready !== (q.size() <= 6)) begin
        n_fail++; $display("FAIL wrap_ready c%0d: got %b want %b",
                           c, in_ready, q.size() <= 6);
      end
      acc = $urandom_range(0, nv);
      push = pushed < 20 && q.size() <= 6 && $urandom_range(0, 3) != 0;
      in_valid = push;
      in_pc = pc;
      in_instr[0] = ADDI1;
      in_mask = 2'b01;
      out_accept = 2'(acc);
      cyc();
      for (int k = 0; k < acc; k++)
        void'(q.pop_front());
      if (push) begin
        q.push_back(pc);
        pc = pc + 64'd4;
        pushed++;
      end
    end
    out_accept = 2'd0;
    push_pkt(64'h6F00, ADDI1, ADDI2, 2'b01, 1'b0);
    n_chk++;
    if (out_valid[0] !== 1'b1) begin
      n_fail++; $display("FAIL pre_rst: valid=%b want lane0 set", out_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (out_valid !== 2'b00 || dut.count !== 4'd0) begin
      n_fail++; $display("FAIL async_rst: valid=%b count=%0d want 00/0",
                         out_valid, dut.count);
    end
    cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  initial begin
    flush = 1'b0;
    priv_mode = PRIV_M;
    in_valid = 1'b0;
    in_pc = '0;
    in_instr = '0;
    in_mask = '0;
    in_fault = 1'b0;
    out_accept = 2'd0;
    test_reset();
    test_basic();
    test_full();
    test_serialise();
    test_fault();
    test_priv();
    test_flush();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
